// File: rtl/fifo_nibble_packer.sv
// Pops nibbles from an upstream FIFO and packs NIBBLES of them into one word on a valid/ready port.
// Define FIFO_NIBBLE_PACKER_PARITY_EN to add the registered out_parity output.
module fifo_nibble_packer #(
    parameter  int unsigned DATA_W  = 4,
    parameter  int unsigned NIBBLES = 2,
    localparam int unsigned OUT_W   = DATA_W * NIBBLES,
    localparam int unsigned CW      = $clog2(NIBBLES + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              empty,
    output logic              ren,
    input  logic [DATA_W-1:0] rdata,
    input  logic              flush,
    output logic [OUT_W-1:0]  out_data,
    output logic [CW-1:0]     out_count,
    output logic              out_valid,
    input  logic              out_ready
`ifdef FIFO_NIBBLE_PACKER_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    localparam int unsigned IW = $clog2(NIBBLES);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [OUT_W-1:0] buf_q, buf_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;
    logic             parity_q, parity_d;

    // Pop only while filling; reset gating keeps the FIFO untouched during reset.
    assign ren = ~RESET & (state_q == FILL) & ~empty;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        buf_d    = buf_q;
        count_d  = count_q;
        valid_d  = valid_q;
        parity_d = parity_q;
        case (state_q)
            FILL: begin
                for (int i = 0; i < int'(NIBBLES); i++) begin
                    if (ren && (idx_q == IW'(i))) begin
                        buf_d[i*DATA_W +: DATA_W] = rdata;
                    end
                end
                if (ren && ((idx_q == IW'(NIBBLES - 1)) || flush)) begin
                    state_d  = HOLD;
                    valid_d  = 1'b1;
                    count_d  = CW'(idx_q) + CW'(1);
                    idx_d    = '0;
                    parity_d = ^buf_d;
                end else if (ren) begin
                    idx_d = idx_q + IW'(1);
                end else if (flush && (idx_q != '0)) begin
                    // Partial word; a flush with nothing captured is dropped.
                    state_d  = HOLD;
                    valid_d  = 1'b1;
                    count_d  = CW'(idx_q);
                    idx_d    = '0;
                    parity_d = ^buf_d;
                end
            end
            HOLD: begin
                if (valid_q && out_ready) begin
                    state_d  = FILL;
                    valid_d  = 1'b0;
                    buf_d    = '0;
                    count_d  = '0;
                    parity_d = 1'b0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= FILL;
            idx_q    <= '0;
            buf_q    <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            buf_q    <= buf_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            parity_q <= parity_d;
        end
    end

    assign out_data  = buf_q;
    assign out_count = count_q;
    assign out_valid = valid_q;

`ifdef FIFO_NIBBLE_PACKER_PARITY_EN
    assign out_parity = parity_q;
`else
    logic unused_parity;
    assign unused_parity = parity_q;
`endif

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Directed bench for fifo_nibble_packer: a vector table on a 2-nibble instance plus
// hand-written sequences on a 4-nibble instance.
module tb_fifo_nibble_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 2-nibble instance
    logic       rst2 = 1'b1, empty2 = 1'b1, flush2 = 1'b0, ready2 = 1'b0;
    logic [3:0] rdata2 = '0;
    logic       ren2, valid2;
    logic [7:0] data2;
    logic [1:0] count2;

    // 4-nibble instance
    logic        rst4 = 1'b1, empty4 = 1'b1, flush4 = 1'b0, ready4 = 1'b0;
    logic [3:0]  rdata4 = '0;
    logic        ren4, valid4;
    logic [15:0] data4;
    logic [2:0]  count4;

`ifdef FIFO_NIBBLE_PACKER_PARITY_EN
    logic par2, par4;
`endif

    fifo_nibble_packer #(.DATA_W(4), .NIBBLES(2)) u_dut2 (
        .CLK       (clk),
        .RESET     (rst2),
        .empty     (empty2),
        .ren       (ren2),
        .rdata     (rdata2),
        .flush     (flush2),
        .out_data  (data2),
        .out_count (count2),
        .out_valid (valid2),
        .out_ready (ready2)
`ifdef FIFO_NIBBLE_PACKER_PARITY_EN
        ,
        .out_parity(par2)
`endif
    );

    fifo_nibble_packer #(.DATA_W(4), .NIBBLES(4)) u_dut4 (
        .CLK       (clk),
        .RESET     (rst4),
        .empty     (empty4),
        .ren       (ren4),
        .rdata     (rdata4),
        .flush     (flush4),
        .out_data  (data4),
        .out_count (count4),
        .out_valid (valid4),
        .out_ready (ready4)
`ifdef FIFO_NIBBLE_PACKER_PARITY_EN
        ,
        .out_parity(par4)
`endif
    );

    typedef struct {
        logic       rst;
        logic       empty;
        logic [3:0] rdata;
        logic       flush;
        logic       ready;
        logic       ren;
        logic       valid;
        logic [7:0] data;
        logic [1:0] count;
        logic       par;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs after the falling edge, check ren before the rising edge, then registered outputs.
    task automatic step4(input logic rst, input logic emp, input logic [3:0] rd, input logic fl,
                         input logic rdy, input logic e_ren, input logic e_valid,
                         input logic [15:0] e_data, input logic [2:0] e_count, input string tag);
        @(negedge clk);
        rst4 = rst; empty4 = emp; rdata4 = rd; flush4 = fl; ready4 = rdy;
        #1;
        chk({tag, ".ren"}, 32'(ren4), 32'(e_ren));
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, 32'(valid4), 32'(e_valid));
        chk({tag, ".data"}, 32'(data4), 32'(e_data));
        chk({tag, ".count"}, 32'(count4), 32'(e_count));
    endtask

    initial begin
        // rst empty rdata flush ready | ren valid data count par
        vq.push_back('{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0}); // reset
        vq.push_back('{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 2'd0, 1'b0}); // normal pack
        vq.push_back('{1'b0, 1'b0, 4'hA, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA3, 2'd2, 1'b0});
        vq.push_back('{1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0}); // accept, no pop
        vq.push_back('{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 4'hC, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0C, 2'd0, 1'b0}); // backpressure
        vq.push_back('{1'b0, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5C, 2'd2, 1'b0});
        for (int i = 0; i < 5; i++)
            vq.push_back('{1'b0, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5C, 2'd2, 1'b0});
        vq.push_back('{1'b0, 1'b0, 4'h9, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 4'h7, 1'b0, 1'b1, 1'b1, 1'b0, 8'h07, 2'd0, 1'b0}); // fill resumes
        vq.push_back('{1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 2'd1, 1'b1}); // flush partial
        vq.push_back('{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0}); // flush at idx 0
        vq.push_back('{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 2'd0, 1'b0}); // reset in HOLD
        vq.push_back('{1'b0, 1'b0, 4'hA, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA3, 2'd2, 1'b0});
        vq.push_back('{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 2'd0, 1'b0}); // word 0x11
        vq.push_back('{1'b0, 1'b0, 4'h1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 2'd2, 1'b0});
        vq.push_back('{1'b0, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 2'd0, 1'b0}); // word 0x13
        vq.push_back('{1'b0, 1'b0, 4'h1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h13, 2'd2, 1'b1});
        vq.push_back('{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0});

        foreach (vq[i]) begin
            @(negedge clk);
            rst2 = vq[i].rst; empty2 = vq[i].empty; rdata2 = vq[i].rdata;
            flush2 = vq[i].flush; ready2 = vq[i].ready;
            #1;
            chk($sformatf("v%0d.ren", i), 32'(ren2), 32'(vq[i].ren));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.valid", i), 32'(valid2), 32'(vq[i].valid));
            chk($sformatf("v%0d.data", i), 32'(data2), 32'(vq[i].data));
            chk($sformatf("v%0d.count", i), 32'(count2), 32'(vq[i].count));
`ifdef FIFO_NIBBLE_PACKER_PARITY_EN
            chk($sformatf("v%0d.parity", i), 32'(par2), 32'(vq[i].par));
`endif
        end

        // Four-nibble instance: flush with a simultaneous pop, then a full word.
        step4(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, "r4");
        step4(1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 3'd0, "fp1");
        step4(1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0021, 3'd0, "fp2");
        step4(1'b0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0321, 3'd3, "fp3");
`ifdef FIFO_NIBBLE_PACKER_PARITY_EN
        chk("fp3.parity", 32'(par4), 32'(1'b0));
`endif
        step4(1'b0, 1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0321, 3'd3, "hold4");
        step4(1'b0, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, "acc4");
        step4(1'b0, 1'b0, 4'h4, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0004, 3'd0, "w1");
        step4(1'b0, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0054, 3'd0, "w2");
        step4(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0054, 3'd0, "wstall");
        step4(1'b0, 1'b0, 4'h6, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0654, 3'd0, "w3");
        step4(1'b0, 1'b0, 4'h7, 1'b0, 1'b0, 1'b1, 1'b1, 16'h7654, 3'd4, "w4");
`ifdef FIFO_NIBBLE_PACKER_PARITY_EN
        chk("w4.parity", 32'(par4), 32'(1'b0));
`endif
        step4(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, "acc4b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
